// File: rtl/seq_bit_serializer_if.sv
// Word-in / bit-out bus of the serializer; slave is the serializer, master is the upstream/observer side.
// din_ready is the only combinational return path; everything else toward the master is registered.
interface seq_bit_serializer_if #(
   parameter int WIDTH = 8
) ();
   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] din;
   logic             din_valid;
   logic             din_ready;
   logic             serial_out;
   logic             out_valid;
   logic [CW-1:0]    bit_count;
   logic             word_done;
   logic             busy;

   modport slave (
      input  din, din_valid,
      output din_ready, serial_out, out_valid, bit_count, word_done, busy
   );

   modport master (
      output din, din_valid,
      input  din_ready, serial_out, out_valid, bit_count, word_done, busy
   );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial shifter with a one-word hold buffer; first bit 1 clk after an idle transfer.
// Backpressure: din_ready = ~hold_full, so at most one word in flight plus one held.
module seq_bit_serializer #(
   parameter int WIDTH      = 8,
   parameter bit MSB_FIRST  = 1'b1,
   parameter bit IDLE_LEVEL = 1'b0
) (
   input logic                 clk,
   input logic                 reset,
   seq_bit_serializer_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic [WIDTH-1:0] hreg_q, hreg_d;
   logic             hold_full_q, hold_full_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             serial_q, serial_d;
   logic             out_valid_q, out_valid_d;
   logic             word_done_q, word_done_d;
   logic             busy_q, busy_d;
   logic             xfer;
   logic [WIDTH-1:0] sreg_shifted;

   assign bus.din_ready  = ~hold_full_q;
   assign xfer           = bus.din_valid & ~hold_full_q;
   assign sreg_shifted   = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};

   always_comb begin
      state_d     = state_q;
      sreg_d      = sreg_q;
      hreg_d      = hreg_q;
      hold_full_d = hold_full_q;
      cnt_d       = cnt_q;

      case (state_q)
         IDLE: begin
            if (xfer) begin
               sreg_d  = bus.din;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            if (cnt_q != LAST) begin
               sreg_d = sreg_shifted;
               cnt_d  = cnt_q + CW'(1);
               if (xfer) begin
                  hreg_d      = bus.din;
                  hold_full_d = 1'b1;
               end
            end else begin
               // Closing edge of a word: held word wins over a fresh bypass transfer.
               cnt_d = '0;
               if (hold_full_q) begin
                  sreg_d      = hreg_q;
                  hold_full_d = 1'b0;
               end else if (xfer) begin
                  sreg_d = bus.din;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      out_valid_d = (state_d == SHIFT);
      serial_d    = IDLE_LEVEL;
      if (state_d == SHIFT) begin
         serial_d = MSB_FIRST ? sreg_d[WIDTH-1] : sreg_d[0];
      end
      word_done_d = (state_d == SHIFT) && (cnt_d == LAST);
      busy_d      = (state_d == SHIFT) || hold_full_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         sreg_q      <= '0;
         hreg_q      <= '0;
         hold_full_q <= 1'b0;
         cnt_q       <= '0;
         serial_q    <= IDLE_LEVEL;
         out_valid_q <= 1'b0;
         word_done_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         sreg_q      <= sreg_d;
         hreg_q      <= hreg_d;
         hold_full_q <= hold_full_d;
         cnt_q       <= cnt_d;
         serial_q    <= serial_d;
         out_valid_q <= out_valid_d;
         word_done_q <= word_done_d;
         busy_q      <= busy_d;
      end
   end

   assign bus.serial_out = serial_q;
   assign bus.out_valid  = out_valid_q;
   assign bus.bit_count  = cnt_q;
   assign bus.word_done  = word_done_q;
   assign bus.busy       = busy_q;
endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench: vector table for reset/single/back-to-back/mid-word reset, then
// hand-written backpressure stream and an LSB-first 4-bit instance.
module tb_seq_bit_serializer;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   seq_bit_serializer_if #(.WIDTH(8)) bus8 ();
   seq_bit_serializer_if #(.WIDTH(4)) bus4 ();

   seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut8 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus8)
   );

   seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (bus4)
   );

   typedef struct {
      logic       rst;
      logic [7:0] din;
      logic       dv;
      logic       ov;
      logic       so;
      logic [2:0] bc;
      logic       wd;
      logic       busy;
      logic       rdy;
   } vec_t;

   vec_t vecs[$];
   int   total  = 0;
   int   passed = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
   endtask

   task automatic add(input logic rst, input logic [7:0] d, input logic dv,
                      input logic ov, input logic so, input logic [2:0] bc,
                      input logic wd, input logic busy, input logic rdy);
      vec_t v;
      v.rst = rst; v.din = d; v.dv = dv; v.ov = ov; v.so = so;
      v.bc = bc; v.wd = wd; v.busy = busy; v.rdy = rdy;
      vecs.push_back(v);
   endtask

   initial begin
      logic [7:0]  w[3];
      int          acc_edge[3];
      int          idx, nbits, first, last, nwd;
      logic [23:0] got;
      logic        acc;
      logic        e6_so[4];

      reset          = 1'b1;
      bus8.din       = 8'h00;
      bus8.din_valid = 1'b0;
      bus4.din       = 4'h0;
      bus4.din_valid = 1'b0;

      // Each row: inputs before the edge, outputs expected just after it.
      //   rst  din    dv  ov so bc wd busy rdy
      // Reset held 2 clks with din_valid high
      add(1, 8'hFF, 1, 0, 0, 0, 0, 0, 1);
      add(1, 8'hFF, 1, 0, 0, 0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
      // Single word 1001_0010
      add(0, 8'h92, 1, 1, 1, 0, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 1, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 2, 0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 3, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 4, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 5, 0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 6, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 7, 1, 1, 1);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
      // Back-to-back 0x92, 0x49 with din_valid held high
      add(0, 8'h92, 1, 1, 1, 0, 0, 1, 1);
      add(0, 8'h49, 1, 1, 0, 1, 0, 1, 0);
      add(0, 8'h49, 1, 1, 0, 2, 0, 1, 0);
      add(0, 8'h49, 1, 1, 1, 3, 0, 1, 0);
      add(0, 8'h49, 1, 1, 0, 4, 0, 1, 0);
      add(0, 8'h49, 1, 1, 0, 5, 0, 1, 0);
      add(0, 8'h49, 1, 1, 1, 6, 0, 1, 0);
      add(0, 8'h49, 1, 1, 0, 7, 1, 1, 0);
      add(0, 8'h49, 1, 1, 0, 0, 0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 1, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 2, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 3, 0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 4, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 5, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 6, 0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 7, 1, 1, 1);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
      // Reset at bit 3 of 0xFF with 0x5A held, then 0xC3 streams cleanly
      add(0, 8'hFF, 1, 1, 1, 0, 0, 1, 1);
      add(0, 8'h5A, 1, 1, 1, 1, 0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 2, 0, 1, 0);
      add(0, 8'h00, 0, 1, 1, 3, 0, 1, 0);
      add(1, 8'h77, 1, 0, 0, 0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);
      add(0, 8'hC3, 1, 1, 1, 0, 0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 1, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 2, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 3, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 4, 0, 1, 1);
      add(0, 8'h00, 0, 1, 0, 5, 0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 6, 0, 1, 1);
      add(0, 8'h00, 0, 1, 1, 7, 1, 1, 1);
      add(0, 8'h00, 0, 0, 0, 0, 0, 0, 1);

      foreach (vecs[i]) begin
         reset          = vecs[i].rst;
         bus8.din       = vecs[i].din;
         bus8.din_valid = vecs[i].dv;
         @(posedge clk);
         #1;
         chk($sformatf("row%0d_out_valid", i),  32'(bus8.out_valid),  32'(vecs[i].ov));
         chk($sformatf("row%0d_serial_out", i), 32'(bus8.serial_out), 32'(vecs[i].so));
         chk($sformatf("row%0d_bit_count", i),  32'(bus8.bit_count),  32'(vecs[i].bc));
         chk($sformatf("row%0d_word_done", i),  32'(bus8.word_done),  32'(vecs[i].wd));
         chk($sformatf("row%0d_busy", i),       32'(bus8.busy),       32'(vecs[i].busy));
         chk($sformatf("row%0d_din_ready", i),  32'(bus8.din_ready),  32'(vecs[i].rdy));
      end
      reset          = 1'b0;
      bus8.din_valid = 1'b0;

      // Three words offered back-to-back through a valid/ready source
      w[0] = 8'hA5; w[1] = 8'h3C; w[2] = 8'hF0;
      acc_edge[0] = -1; acc_edge[1] = -1; acc_edge[2] = -1;
      idx = 0; nbits = 0; first = -1; last = -1; nwd = 0; got = '0;
      for (int c = 0; c < 30; c++) begin
         bus8.din       = (idx < 3) ? w[idx] : 8'h00;
         bus8.din_valid = (idx < 3);
         acc            = bus8.din_valid & bus8.din_ready;
         @(posedge clk);
         #1;
         if (acc) begin
            acc_edge[idx] = c;
            idx++;
         end
         if (bus8.out_valid) begin
            got = {got[22:0], bus8.serial_out};
            nbits++;
            if (first < 0) first = c;
            last = c;
         end
         if (bus8.word_done) nwd++;
      end
      bus8.din_valid = 1'b0;
      chk("bp_w0_accept_edge", 32'(acc_edge[0]), 32'd0);
      chk("bp_w1_accept_edge", 32'(acc_edge[1]), 32'd1);
      chk("bp_w2_accept_edge", 32'(acc_edge[2]), 32'd9);
      chk("bp_words_accepted", 32'(idx), 32'd3);
      chk("bp_bit_stream", 32'(got), 32'h00A53CF0);
      chk("bp_valid_bits", 32'(nbits), 32'd24);
      chk("bp_contiguous_span", 32'(last - first + 1), 32'd24);
      chk("bp_word_done_count", 32'(nwd), 32'd3);

      // LSB-first 4-bit instance with din = 4'b0001
      e6_so[0] = 1'b1; e6_so[1] = 1'b0; e6_so[2] = 1'b0; e6_so[3] = 1'b0;
      bus4.din       = 4'b0001;
      bus4.din_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(posedge clk);
         #1;
         bus4.din_valid = 1'b0;
         chk($sformatf("lsb_bit%0d_out_valid", k),  32'(bus4.out_valid),  32'd1);
         chk($sformatf("lsb_bit%0d_serial_out", k), 32'(bus4.serial_out), 32'(e6_so[k]));
         chk($sformatf("lsb_bit%0d_bit_count", k),  32'(bus4.bit_count),  32'(k));
         chk($sformatf("lsb_bit%0d_word_done", k),  32'(bus4.word_done),  32'(k == 3));
      end
      @(posedge clk);
      #1;
      chk("lsb_end_out_valid", 32'(bus4.out_valid), 32'd0);
      chk("lsb_end_busy",      32'(bus4.busy),      32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
